// File: rtl/divider_arbiter_pkg.sv
// div_arb_pkg: shared types and constants for the divider arbiter slice.
//   state_t               - sequencer states
//   DEFAULT_NUM_REQ/WIDTH - default requester count and operand width
//   DIV_BY_ZERO_QUOTIENT  - quotient returned for a zero divisor (all ones, sliced to WIDTH <= 64)
package div_arb_pkg;

    localparam int DEFAULT_NUM_REQ = 4;
    localparam int DEFAULT_WIDTH   = 32;

    localparam logic [63:0] DIV_BY_ZERO_QUOTIENT = '1;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        ZERO,
        RESP
    } state_t;

endpackage

// File: rtl/divider_arbiter_if.sv
// divider_arbiter_if: requester-side bus of the divider arbiter.
//   req_valid/req_ready       - per-requester handshake
//   req_dividend/req_divisor  - per-requester operands
//   resp_valid                - one-hot single-cycle result strobe
//   resp_quotient/remainder   - shared result bus
//   master: requesters, slave: arbiter
interface divider_arbiter_if
    import div_arb_pkg::*;
#(
    parameter int NUM_REQ = DEFAULT_NUM_REQ,
    parameter int WIDTH   = DEFAULT_WIDTH
);

    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ-1:0]            req_ready;
    logic [NUM_REQ-1:0][WIDTH-1:0] req_dividend;
    logic [NUM_REQ-1:0][WIDTH-1:0] req_divisor;
    logic [NUM_REQ-1:0]            resp_valid;
    logic [WIDTH-1:0]              resp_quotient;
    logic [WIDTH-1:0]              resp_remainder;

    modport master (
        output req_valid, req_dividend, req_divisor,
        input  req_ready, resp_valid, resp_quotient, resp_remainder
    );

    modport slave (
        input  req_valid, req_dividend, req_divisor,
        output req_ready, resp_valid, resp_quotient, resp_remainder
    );

endinterface

// File: rtl/divider_arbiter_rr_arbiter.sv
// rr_arbiter: combinational round-robin picker.
//   req       - request vector
//   ptr       - highest-priority index this round
//   grant     - one-hot winner (zero if no request)
//   grant_idx - index of the winner
//   grant_any - any request present
module rr_arbiter
    import div_arb_pkg::*;
#(
    parameter int NUM_REQ = DEFAULT_NUM_REQ,
    localparam int IDXW   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDXW-1:0]    ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDXW-1:0]    grant_idx,
    output logic               grant_any
);

    // (base + off) mod NUM_REQ; base and off are both below NUM_REQ so one subtraction suffices
    function automatic logic [IDXW-1:0] wrap_add(input logic [IDXW-1:0] base, input int off);
        logic [IDXW:0] sum;
        sum = {1'b0, base} + (IDXW+1)'(off);
        return (sum >= (IDXW+1)'(NUM_REQ)) ? sum[IDXW-1:0] - IDXW'(NUM_REQ) : sum[IDXW-1:0];
    endfunction

    // scan from the farthest offset down so the nearest requester at or after ptr wins
    always_comb begin
        grant_idx = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--)
            if (req[wrap_add(ptr, k)])
                grant_idx = wrap_add(ptr, k);
        grant_any = |req;
        grant     = grant_any ? NUM_REQ'(1) << grant_idx : '0;
    end

endmodule

// File: rtl/divider_arbiter.sv
// divider_arbiter: shares one iterative divider among NUM_REQ requesters, one division in flight.
//   clk, rst          - clock, asynchronous active-high reset (shared with the divider)
//   bus (slave)       - requester handshake, operands and shared result bus
//   div_dividend/div_divisor/div_in_valid - operands and start strobe to the divider
//   div_quotient/div_remainder/div_out_valid/div_busy - result and status from the divider
module divider_arbiter
    import div_arb_pkg::*;
#(
    parameter int NUM_REQ = DEFAULT_NUM_REQ,
    parameter int WIDTH   = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    divider_arbiter_if.slave bus,
    output logic [WIDTH-1:0] div_dividend,
    output logic [WIDTH-1:0] div_divisor,
    output logic             div_in_valid,
    input  logic [WIDTH-1:0] div_quotient,
    input  logic [WIDTH-1:0] div_remainder,
    input  logic             div_out_valid,
    input  logic             div_busy
);

    localparam int IDXW = $clog2(NUM_REQ);

    state_t             state_q, state_d;
    logic [IDXW-1:0]    rr_ptr_q, rr_ptr_d;
    logic [IDXW-1:0]    owner_q, owner_d;
    logic [WIDTH-1:0]   dividend_q, dividend_d;
    logic [WIDTH-1:0]   divisor_q, divisor_d;
    logic [WIDTH-1:0]   quotient_q, quotient_d;
    logic [WIDTH-1:0]   remainder_q, remainder_d;
    logic [NUM_REQ-1:0] grant;
    logic [IDXW-1:0]    grant_idx;
    logic               grant_any;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
        .req      (bus.req_valid),
        .ptr      (rr_ptr_q),
        .grant    (grant),
        .grant_idx(grant_idx),
        .grant_any(grant_any)
    );

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        owner_d     = owner_q;
        dividend_d  = dividend_q;
        divisor_d   = divisor_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        case (state_q)
            IDLE: if (grant_any) begin
                owner_d    = grant_idx;
                dividend_d = bus.req_dividend[grant_idx];
                divisor_d  = bus.req_divisor[grant_idx];
                rr_ptr_d   = (grant_idx == IDXW'(NUM_REQ - 1)) ? '0 : grant_idx + IDXW'(1);
                state_d    = (bus.req_divisor[grant_idx] == '0) ? ZERO : ISSUE;
            end
            ISSUE: state_d = div_busy ? ISSUE : WAIT;
            WAIT: if (div_out_valid) begin
                quotient_d  = div_quotient;
                remainder_d = div_remainder;
                state_d     = RESP;
            end
            // zero divisor is answered locally; the divider is never started
            ZERO: begin
                quotient_d  = DIV_BY_ZERO_QUOTIENT[WIDTH-1:0];
                remainder_d = dividend_q;
                state_d     = RESP;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            rr_ptr_q    <= '0;
            owner_q     <= '0;
            dividend_q  <= '0;
            divisor_q   <= '0;
            quotient_q  <= '0;
            remainder_q <= '0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            owner_q     <= owner_d;
            dividend_q  <= dividend_d;
            divisor_q   <= divisor_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
        end
    end

    // ready is gated by rst so every output reads zero while reset is held
    assign bus.req_ready      = (state_q == IDLE && !rst) ? grant : '0;
    assign bus.resp_valid     = (state_q == RESP) ? NUM_REQ'(1) << owner_q : '0;
    assign bus.resp_quotient  = quotient_q;
    assign bus.resp_remainder = remainder_q;
    assign div_dividend       = dividend_q;
    assign div_divisor        = divisor_q;
    assign div_in_valid       = state_q == ISSUE && !div_busy;

endmodule

// File: tb/tb_divider_arbiter.sv
// tb_divider_arbiter: directed and randomized checks of divider_arbiter against a transaction-level model.
module tb_divider_arbiter;
    import div_arb_pkg::*;

    localparam int N = 4;
    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] div_dividend, div_divisor, div_quotient, div_remainder;
    logic         div_in_valid, div_out_valid, div_busy;

    divider_arbiter_if #(.NUM_REQ(N), .WIDTH(W)) bus ();

    divider_arbiter #(.NUM_REQ(N), .WIDTH(W)) dut (
        .clk          (clk),
        .rst          (rst),
        .bus          (bus.slave),
        .div_dividend (div_dividend),
        .div_divisor  (div_divisor),
        .div_in_valid (div_in_valid),
        .div_quotient (div_quotient),
        .div_remainder(div_remainder),
        .div_out_valid(div_out_valid),
        .div_busy     (div_busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int           owner;
        logic [W-1:0] q;
        logic [W-1:0] r;
        int           cyc;
    } resp_t;

    int           checks = 0, errors = 0, cyc = 0, iv_count = 0;
    bit           pend[N], rep[N];
    logic [W-1:0] pa[N], pb[N];
    int           waits[N];
    bit           m_busy, m_issued;
    int           m_ptr, m_owner, m_hs, m_due, m_issue_cyc;
    logic [W-1:0] m_a, m_b, last_q, last_r;
    int           dv_cnt, dv_force, dv_min = 1, dv_max = 4;
    logic [W-1:0] dv_q, dv_r;
    bit           spurious, rand_mode, busy_on_hs;
    resp_t        log_q[$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            pend[i] = 0; rep[i] = 0; waits[i] = 0;
        end
        m_busy = 0; m_issued = 0; m_ptr = 0; m_due = -1; m_hs = 0;
        last_q = '0; last_r = '0; dv_cnt = 0; dv_force = 0;
    endtask

    task automatic reset_checks(input string tag);
        check({tag, "_req_ready"}, bus.req_ready, 0);
        check({tag, "_resp_valid"}, bus.resp_valid, 0);
        check({tag, "_div_in_valid"}, div_in_valid, 0);
        check({tag, "_div_dividend"}, div_dividend, 0);
        check({tag, "_div_divisor"}, div_divisor, 0);
        check({tag, "_resp_quotient"}, bus.resp_quotient, 0);
        check({tag, "_resp_remainder"}, bus.resp_remainder, 0);
    endtask

    task automatic observe();
        logic [N-1:0] exp_rdy, exp_rv;
        logic [W-1:0] exp_q, exp_r;
        bit           exp_iv;
        int           w;
        exp_rdy = '0; exp_rv = '0; exp_q = '0; exp_r = '0; w = -1;
        if (!rst && !m_busy)
            for (int k = 0; k < N; k++)
                if (w < 0 && pend[(m_ptr + k) % N]) w = (m_ptr + k) % N;
        if (w >= 0) exp_rdy[w] = 1'b1;
        check("req_ready", bus.req_ready, exp_rdy);
        if (div_in_valid) iv_count++;
        exp_iv = m_busy && m_b != 0 && !m_issued && cyc > m_hs && !div_busy;
        check("div_in_valid", div_in_valid, exp_iv);
        if (exp_iv) begin
            check("div_dividend", div_dividend, m_a);
            check("div_divisor", div_divisor, m_b);
            m_issued = 1; m_issue_cyc = cyc;
        end
        if (div_in_valid && !div_busy) begin
            dv_cnt = $urandom_range(dv_max, dv_min);
            dv_q = (div_divisor != 0) ? div_dividend / div_divisor : '1;
            dv_r = (div_divisor != 0) ? div_dividend % div_divisor : div_dividend;
        end
        if (m_busy && cyc == m_due) begin
            exp_rv[m_owner] = 1'b1;
            exp_q = (m_b == 0) ? '1 : m_a / m_b;
            exp_r = (m_b == 0) ? m_a : m_a % m_b;
        end
        check("resp_valid", bus.resp_valid, exp_rv);
        if (exp_rv != 0) begin
            check("resp_quotient", bus.resp_quotient, exp_q);
            check("resp_remainder", bus.resp_remainder, exp_r);
            last_q = exp_q; last_r = exp_r; m_busy = 0;
        end else begin
            check("hold_quotient", bus.resp_quotient, last_q);
            check("hold_remainder", bus.resp_remainder, last_r);
        end
        if (bus.resp_valid != 0)
            for (int i = 0; i < N; i++)
                if (bus.resp_valid[i]) log_q.push_back('{i, bus.resp_quotient, bus.resp_remainder, cyc});
        if (m_busy && m_issued && m_due < 0 && div_out_valid) m_due = cyc + 1;
        if (w >= 0) begin
            m_busy = 1; m_owner = w; m_a = pa[w]; m_b = pb[w]; m_hs = cyc; m_issued = 0;
            m_due = (pb[w] == 0) ? cyc + 2 : -1;
            m_ptr = (w + 1) % N;
            check("starvation_bound", waits[w] <= N - 1, 1);
            for (int i = 0; i < N; i++)
                if (pend[i] && i != w) waits[i]++;
            waits[w] = 0;
            if (!rep[w]) pend[w] = 0;
            if (busy_on_hs) dv_force = 5;
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
        cyc++;
        if (rand_mode) begin
            for (int i = 0; i < N; i++) begin
                if (pend[i]) begin
                    if ($urandom_range(31, 0) == 0) begin
                        pend[i] = 0; waits[i] = 0;
                    end
                end else if ($urandom_range(3, 0) == 0) begin
                    pend[i] = 1;
                    pa[i] = $urandom;
                    case ($urandom_range(3, 0))
                        0: pb[i] = '0;
                        1: pb[i] = $urandom_range(15, 1);
                        default: pb[i] = $urandom >> $urandom_range(31, 0);
                    endcase
                end
            end
            spurious = !m_busy && dv_cnt == 0 && $urandom_range(15, 0) == 0;
            busy_on_hs = $urandom_range(7, 0) == 0;
        end
        for (int i = 0; i < N; i++) begin
            bus.req_valid[i]    = pend[i];
            bus.req_dividend[i] = pend[i] ? pa[i] : $urandom;
            bus.req_divisor[i]  = pend[i] ? pb[i] : $urandom;
        end
        div_out_valid = dv_cnt == 1 || spurious;
        div_busy      = dv_cnt > 1 || dv_force > 0;
        div_quotient  = (dv_cnt == 1) ? dv_q : $urandom;
        div_remainder = (dv_cnt == 1) ? dv_r : $urandom;
        spurious = 0;
        if (dv_cnt > 0) dv_cnt--;
        if (dv_force > 0) dv_force--;
        @(negedge clk);
        observe();
    endtask

    task automatic run_until_idle(input int budget, input string tag);
        int n = 0;
        while ((pend[0] || pend[1] || pend[2] || pend[3] || m_busy) && n < budget) begin
            cycle();
            n++;
        end
        check({tag, "_timeout"}, n < budget, 1);
    endtask

    task automatic set_req(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
        pend[i] = 1; pa[i] = a; pb[i] = b;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int iv0, n;
        rst = 1'b0;
        bus.req_valid = '0; bus.req_dividend = '0; bus.req_divisor = '0;
        div_out_valid = 0; div_busy = 0; div_quotient = '0; div_remainder = '0;
        model_reset();
        #1 rst = 1'b1;
        #1 reset_checks("reset");
        repeat (2) cycle();
        rst = 1'b0;

        // all four at once, pointer at 0 after reset: served 0,1,2,3
        log_q.delete();
        for (int i = 0; i < N; i++) set_req(i, 50_000_000, 1000 << i);
        run_until_idle(200, "all4");
        check("all4_count", log_q.size(), 4);
        for (int i = 0; i < 4 && i < log_q.size(); i++) begin
            check("all4_owner", log_q[i].owner, i);
            check("all4_quotient", log_q[i].q, 50000 >> i);
            check("all4_remainder", log_q[i].r, 0);
        end

        // single requester 0
        log_q.delete();
        set_req(0, 50_000_000, 440);
        run_until_idle(100, "single");
        check("single_count", log_q.size(), 1);
        if (log_q.size() > 0) begin
            check("single_owner", log_q[0].owner, 0);
            check("single_quotient", log_q[0].q, 113636);
            check("single_remainder", log_q[0].r, 160);
        end
        check("single_issue_latency", m_issue_cyc - m_hs, 1);

        // divide by zero from requester 3
        log_q.delete();
        iv0 = iv_count;
        set_req(3, 1234, 0);
        run_until_idle(100, "zero");
        check("zero_no_issue", iv_count - iv0, 0);
        if (log_q.size() > 0) begin
            check("zero_owner", log_q[0].owner, 3);
            check("zero_latency", log_q[0].cyc - m_hs, 2);
            check("zero_quotient", log_q[0].q, 32'hFFFF_FFFF);
            check("zero_remainder", log_q[0].r, 1234);
        end else check("zero_count", log_q.size(), 1);

        // requester 0 held valid, requester 2 asks once: 0,2,0,0
        log_q.delete();
        rep[0] = 1;
        set_req(0, 90_000, 7);
        set_req(2, 77_777, 11);
        n = 0;
        while (log_q.size() < 4 && n < 200) begin
            cycle();
            n++;
        end
        check("rr_timeout", n < 200, 1);
        rep[0] = 0; pend[0] = 0;
        run_until_idle(100, "rr_drain");
        for (int i = 0; i < 4 && i < log_q.size(); i++)
            check("rr_order", log_q[i].owner, (i == 1) ? 2 : 0);

        // divider busy for 5 cycles after the handshake
        log_q.delete();
        iv0 = iv_count;
        busy_on_hs = 1;
        set_req(2, 1_000_000, 3);
        run_until_idle(100, "busy");
        busy_on_hs = 0;
        check("busy_issue_cycle", m_issue_cyc - m_hs, 6);
        check("busy_single_pulse", iv_count - iv0, 1);
        if (log_q.size() > 0) begin
            check("busy_quotient", log_q[0].q, 333333);
            check("busy_remainder", log_q[0].r, 1);
        end else check("busy_count", log_q.size(), 1);

        // reset while waiting on the divider
        dv_min = 20; dv_max = 20;
        set_req(1, 100_000, 7);
        n = 0;
        while (!m_issued && n < 50) begin
            cycle();
            n++;
        end
        cycle();
        #2 rst = 1'b1;
        #1 reset_checks("async_reset");
        model_reset();
        repeat (2) cycle();
        rst = 1'b0;
        dv_min = 1; dv_max = 4;
        log_q.delete();
        repeat (25) cycle();
        check("no_resp_after_reset", log_q.size(), 0);
        set_req(1, 500, 7);
        set_req(3, 600, 9);
        run_until_idle(100, "post_reset");
        if (log_q.size() > 0) check("post_reset_first_owner", log_q[0].owner, 1);
        else check("post_reset_count", log_q.size(), 2);

        // randomized traffic with withdrawals, spurious results and busy stalls
        rand_mode = 1;
        repeat (3000) cycle();
        rand_mode = 0;
        busy_on_hs = 0;
        run_until_idle(500, "random_drain");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/divider_arbiter.md
Name: divider_arbiter

Overview:
Round-robin arbiter and sequencer that shares the single iterative divider among NUM_REQ requesters, such as per-voice period and phase-increment computations.
- Each requester presents a dividend/divisor pair with a valid/ready handshake.
- The block issues one division at a time to the divider and returns the quotient and remainder to the owning requester.
- It sits between the voice/oscillator control logic and the divider instance in top_level.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
WIDTH, 32, operand/result width; must match the divider

Ports:
clk  in  1  system clock (100 MHz)
rst  in  1  asynchronous active-high reset
req_valid  in  NUM_REQ  per-requester request strobe
req_ready  out  NUM_REQ  per-requester accept; one-hot or zero
req_dividend  in  NUM_REQ x WIDTH  per-requester dividend
req_divisor  in  NUM_REQ x WIDTH  per-requester divisor
resp_valid  out  NUM_REQ  one-hot, single-cycle result strobe
resp_quotient  out  WIDTH  result quotient, shared bus
resp_remainder  out  WIDTH  result remainder, shared bus
div_dividend  out  WIDTH  to divider .dividend
div_divisor  out  WIDTH  to divider .divisor
div_in_valid  out  1  to divider .data_in_valid
div_quotient  in  WIDTH  from divider .quotient
div_remainder  in  WIDTH  from divider .remainder
div_out_valid  in  1  from divider .data_out_valid
div_busy  in  1  from divider .busy

Behaviour:
- Reset (async, rst=1): state=IDLE, rr_ptr=0, all outputs 0; operand/result registers cleared. The divider shares rst, so any in-flight division is aborted.
- FSM states: IDLE, ISSUE, WAIT, ZERO, RESP.
- IDLE:
  - req_ready is combinational: one-hot on the round-robin winner among req_valid, searching from rr_ptr upward and wrapping modulo NUM_REQ.
  - Handshake occurs when req_valid[i] & req_ready[i]. The block latches operands and owner index i, and sets rr_ptr <= (i+1) mod NUM_REQ.
  - Next state is ZERO if divisor==0, otherwise ISSUE.
- ISSUE: drive div_dividend/div_divisor from latched operands. Assert div_in_valid=1 only when div_busy=0; on that cycle go to WAIT. While div_busy=1, hold in ISSUE with div_in_valid=0.
- WAIT: div_in_valid=0. On div_out_valid=1, capture div_quotient/div_remainder and go to RESP. A div_out_valid seen in any other state is ignored.
- ZERO: quotient <= all ones, remainder <= latched dividend; go to RESP. The divider is never started for a zero divisor.
- RESP:
  - resp_valid[owner]=1 for exactly one cycle.
  - resp_quotient/resp_remainder are valid only in that cycle and hold their value afterwards until the next RESP.
  - Next state is IDLE.
- Latency: handshake cycle t gives div_in_valid at t+1 (if not busy). resp_valid is asserted one cycle after div_out_valid. For divide-by-zero, resp_valid is asserted at t+2.
- Throughput: one request in flight. No new handshake occurs outside IDLE; req_ready=0 in every non-IDLE state.
- Requester-side rules:
  - Operands must be stable only on the handshake cycle; they are registered at handshake.
  - A requester may deassert req_valid before it is granted. No error results, and it is simply skipped.
  - Multiple simultaneous req_valid: exactly one grant per IDLE visit, in rotating order.
  - No requester waits more than NUM_REQ-1 other grants.
- Width: all operands are WIDTH-bit unsigned; no truncation or extension is performed.

Decomposition:
- Shared package div_arb_pkg: state enum typedef (IDLE, ISSUE, WAIT, ZERO, RESP), default WIDTH/NUM_REQ constants, and DIV_BY_ZERO_QUOTIENT = all ones.
- Sub-module rr_arbiter (parameter NUM_REQ): combinational one-hot grant from request vector and rr_ptr, plus index-of-grant output. It is reused later for voice-trigger arbitration.

Test Plan:
1. Single requester 0: dividend 50_000_000, divisor 440 -> resp_valid[0] one cycle; quotient 113636, remainder 160; req_ready[0] high only in the handshake cycle.
2. All four requesters valid at once, divisors 1000/2000/4000/8000, dividend 50_000_000 -> responses in order 0,1,2,3; quotients 50000/25000/12500/6250; remainders 0.
3. Requester 0 held valid continuously while 2 requests once -> grant order 0,2,0,0…; requester 2 is served within the second grant.
4. Divisor 0, dividend 1234 from requester 3 -> div_in_valid never asserted; resp_valid[3] at handshake+2; quotient 0xFFFFFFFF, remainder 1234.
5. Model divider held busy for 5 cycles after handshake -> div_in_valid stays 0 during busy and pulses once on the first non-busy cycle; result still correct.
6. Assert rst during WAIT -> all outputs 0 immediately (async); no resp_valid is emitted afterwards; a new request after reset completes normally, with rr_ptr starting at 0.
